alu_seq16: RTL and testbench

ALU_SEQ16 -- requirements
Module: alu_seq16

---
 rtl/alu_seq16.sv | 111 +++++++++++
 tb/tb_alu_seq16.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq16.sv
// Nibble-serial sequencer driving an external 4-bit 74181 ALU.
// It processes one 4-bit slice per clock, starting with the least significant slice.
module alu_seq16 #(
    parameter int unsigned NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        op_s,
    input  logic              op_m,
    input  logic              cin,
    input  logic [4*NIB-1:0]  a,
    input  logic [4*NIB-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [4*NIB-1:0]  result,
    output logic              cout,
    output logic              zero,
    output logic [3:0]        alu_a,
    output logic [3:0]        alu_b,
    output logic [3:0]        alu_s,
    output logic              alu_m,
    output logic              alu_c0,
    input  logic [3:0]        alu_f,
    input  logic              alu_c4
);

    localparam int unsigned W  = 4 * NIB;
    localparam int unsigned IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(NIB - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry_reg;   // active-low carry, 74181 convention
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [3:0]    s_reg;
    logic          m_reg;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            idx       <= '0;
            carry_reg <= 1'b1;
            result    <= '0;
            cout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            m_reg     <= 1'b0;
        end else begin
            case (state)
                StIdle, StDone: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        s_reg     <= op_s;
                        m_reg     <= op_m;
                        carry_reg <= ~cin;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    result[{idx, 2'b00} +: 4] <= alu_f;
                    carry_reg                 <= alu_c4;
                    if (idx == LastIdx) begin
                        // Logic mode never reports a carry out.
                        cout  <= m_reg ? 1'b0 : ~alu_c4;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign zero = (result == '0);
    assign a_sh = a_reg >> {idx, 2'b00};
    assign b_sh = b_reg >> {idx, 2'b00};

    always_comb begin
        alu_a  = 4'h0;
        alu_b  = 4'h0;
        alu_s  = 4'h0;
        alu_m  = 1'b1;
        alu_c0 = 1'b1;
        if (state == StRun) begin
            alu_a  = a_sh[3:0];
            alu_b  = b_sh[3:0];
            alu_s  = s_reg;
            alu_m  = m_reg;
            alu_c0 = carry_reg;
        end
    end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with a behavioural 74181 slice model.
module tb_alu_seq16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op_s;
    logic        op_m;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        cout;
    logic        zero;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_s;
    logic        alu_m;
    logic        alu_c0;
    logic [3:0]  alu_f;
    logic        alu_c4;
    logic [4:0]  sum;

    int checks;
    int failures;

    alu_seq16 #(.NIB(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op_s   (op_s),
        .op_m   (op_m),
        .cin    (cin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_s  (alu_s),
        .alu_m  (alu_m),
        .alu_c0 (alu_c0),
        .alu_f  (alu_f),
        .alu_c4 (alu_c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 74181 with active-high data: S=1001 is A plus B, S=0110 is A minus B minus 1
    // (arithmetic) or A xor B (logic). Carry in and carry out are active-low.
    always_comb begin
        sum = 5'd0;
        if (alu_s == 4'b1001)
            sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, ~alu_c0};
        else
            sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, ~alu_c0};
        if (alu_m)
            alu_f = (alu_s == 4'b0110) ? (alu_a ^ alu_b) : ~(alu_a ^ alu_b);
        else
            alu_f = sum[3:0];
        alu_c4 = ~sum[4];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] s, input logic m, input logic c,
                          input logic [15:0] va, input logic [15:0] vb);
        op_s = s;
        op_m = m;
        cin  = c;
        a    = va;
        b    = vb;
    endtask

    // Start an operation; on return the bench sits in cycle t+5.
    task automatic run_op(input string tag, input logic [3:0] s, input logic m, input logic c,
                          input logic [15:0] va, input logic [15:0] vb,
                          input logic [15:0] exp_res, input logic exp_cout);
        set_op(s, m, c, va, vb);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_t1"}, 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        check({tag, "_nodone_t4"}, 32'(done), 32'd0);
        tick();
        check({tag, "_done_t5"}, 32'(done), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check({tag, "_zero"}, 32'(zero), 32'(exp_res == 16'h0000));
    endtask

    initial begin
        int pulses;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        set_op(4'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_alu_m", 32'(alu_m), 32'd1);
        check("rst_alu_c0", 32'(alu_c0), 32'd1);
        rst = 1'b0;
        tick();

        // Addition with carry ripple between slices
        set_op(4'b1001, 1'b0, 1'b0, 16'h12FF, 16'h0001);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("add_alu_a_slice0", 32'(alu_a), 32'hF);
        check("add_alu_b_slice0", 32'(alu_b), 32'h1);
        tick();
        check("add_alu_a_slice1", 32'(alu_a), 32'hF);
        check("add_alu_c0_slice1", 32'(alu_c0), 32'd0);
        tick();
        tick();
        tick();
        check("add_done", 32'(done), 32'd1);
        check("add_busy_done", 32'(busy), 32'd0);
        check("add_result", 32'(result), 32'h1300);
        check("add_cout", 32'(cout), 32'd0);
        check("add_zero", 32'(zero), 32'd0);
        tick();
        check("add_done_pulse", 32'(done), 32'd0);
        check("add_hold", 32'(result), 32'h1300);
        check("idle_alu_a", 32'(alu_a), 32'd0);

        run_op("sub_pos", 4'b0110, 1'b0, 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1);
        tick();
        run_op("sub_neg", 4'b0110, 1'b0, 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
        tick();
        run_op("wrap", 4'b1001, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        tick();

        // Logic XOR; carry in at the first slice must be the inactive level
        set_op(4'b0110, 1'b1, 1'b0, 16'hFFFF, 16'h0F0F);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("xor_alu_c0_t1", 32'(alu_c0), 32'd1);
        check("xor_alu_m_t1", 32'(alu_m), 32'd1);
        tick();
        tick();
        tick();
        tick();
        check("xor_done", 32'(done), 32'd1);
        check("xor_result", 32'(result), 32'hF0F0);
        check("xor_cout", 32'(cout), 32'd0);
        tick();

        // Start during RUN is ignored; start in the DONE cycle is accepted
        set_op(4'b1001, 1'b0, 1'b0, 16'h0010, 16'h0020);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_op(4'b0110, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("ign_done_t5", 32'(done), 32'd1);
        check("ign_result", 32'(result), 32'h0030);
        set_op(4'b1001, 1'b0, 1'b0, 16'h1111, 16'h2222);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        tick();
        tick();
        tick();
        check("b2b_nodone_t9", 32'(done), 32'd0);
        tick();
        check("b2b_done_t10", 32'(done), 32'd1);
        check("b2b_result", 32'(result), 32'h3333);
        tick();

        // Asynchronous reset in the middle of a run
        set_op(4'b1001, 1'b0, 1'b0, 16'h4444, 16'h1111);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_result", 32'(result), 32'd0);
        check("arst_zero", 32'(zero), 32'd1);
        check("arst_alu_c0", 32'(alu_c0), 32'd1);
        tick();
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) pulses++;
        end
        check("arst_no_done", 32'(pulses), 32'd0);
        run_op("post_rst", 4'b1001, 1'b0, 1'b0, 16'h4444, 16'h1111, 16'h5555, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
